// File: rtl/ws2812_multi_driver.sv
// Multi-strip WS2812 serial driver: NUM_CH strips in lock-step, pixels fetched from
// an external frame RAM one LED ahead and scaled by a global brightness factor.
//
// state | meaning
// IDLE  | waiting for start (ignored while busy is still high)
// FETCH | read strobe for pixel 0
// WAIT  | capture + scale pixel 0 into the shift registers
// SHIFT | serialise 24 bits per LED, prefetching the next LED into hold_q
// LATCH | leds low for T_RESET cycles, done on the last one
module ws2812_multi_driver #(
    parameter int NUM_CH   = 4,
    parameter int NUM_LEDS = 56,
    parameter int ADDR_W   = 6,
    parameter int T_BIT    = 125,
    parameter int T0H      = 34,
    parameter int T1H      = 89,
    parameter int T_RESET  = 5900
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [7:0]             brightness,
    output logic                   pix_rd,
    output logic [ADDR_W-1:0]      pix_addr,
    input  logic [24*NUM_CH-1:0]   pix_data,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_CH-1:0]      leds
);

    localparam int CYC_W = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam int LAT_W = (T_RESET > 1) ? $clog2(T_RESET) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
    localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H);
    localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(T_RESET - 1);
    localparam logic [ADDR_W-1:0] LED_LAST = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_LATCH} state_t;

    state_t                   state_q, state_d;
    logic [CYC_W-1:0]         cyc_q, cyc_d;
    logic [4:0]               bit_q, bit_d;
    logic [ADDR_W-1:0]        led_q, led_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic [7:0]               bright_q, bright_d;
    logic [NUM_CH-1:0][23:0]  shift_q, shift_d;
    logic [NUM_CH-1:0][23:0]  hold_q, hold_d;
    logic [NUM_CH-1:0][23:0]  scaled;
    logic                     cap_q, cap_d;
    logic                     pix_rd_q, pix_rd_d;
    logic [ADDR_W-1:0]        pix_addr_q, pix_addr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [NUM_CH-1:0]        leds_q, leds_d;

    logic accept, bit_end, led_end, last_led, lat_end;

    // Product of byte and (brightness+1) fits in 16 bits; the upper byte is the result.
    function automatic logic [23:0] scale_px(input logic [23:0] px, input logic [7:0] b);
        logic [15:0] k;
        logic [15:0] p;
        logic [23:0] r;
        k = {8'd0, b} + 16'd1;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            p = {8'd0, px[8*i +: 8]} * k;
            r[8*i +: 8] = p[15:8];
        end
        return r;
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            scaled[c] = scale_px(pix_data[24*c +: 24], bright_q);
        end
    end

    assign accept   = (state_q == S_IDLE) && start && !busy_q;
    assign bit_end  = (cyc_q == CYC_LAST);
    assign led_end  = bit_end && (bit_q == 5'd0);
    assign last_led = (led_q == LED_LAST);
    assign lat_end  = (lat_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_FETCH;
            S_FETCH: state_d = abort ? S_LATCH : S_WAIT;
            S_WAIT:  state_d = abort ? S_LATCH : S_SHIFT;
            S_SHIFT: if (abort || (led_end && last_led)) state_d = S_LATCH;
            S_LATCH: if (lat_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        led_d      = led_q;
        lat_d      = lat_q;
        bright_d   = bright_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        cap_d      = 1'b0;
        pix_rd_d   = 1'b0;
        pix_addr_d = pix_addr_q;
        busy_d     = done_q ? 1'b0 : busy_q;
        done_d     = 1'b0;
        leds_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    bright_d   = brightness;
                    busy_d     = 1'b1;
                    pix_rd_d   = 1'b1;
                    pix_addr_d = '0;
                end
            end
            S_WAIT: begin
                if (!abort) begin
                    shift_d = scaled;
                    cyc_d   = '0;
                    bit_d   = 5'd23;
                    led_d   = '0;
                    // Prefetch of LED 1 lands on cycle 0 of bit 23 of LED 0.
                    if (NUM_LEDS > 1) begin
                        pix_rd_d   = 1'b1;
                        pix_addr_d = ADDR_W'(1);
                    end
                end
            end
            S_SHIFT: begin
                if (!abort) begin
                    cap_d = pix_rd_q;
                    if (cap_q) hold_d = scaled;
                    for (int c = 0; c < NUM_CH; c++) begin
                        leds_d[c] = (cyc_q < (shift_q[c][bit_q] ? T1H_C : T0H_C));
                    end
                    if (bit_end) begin
                        cyc_d = '0;
                        if (bit_q == 5'd0) begin
                            if (!last_led) begin
                                shift_d = hold_q;
                                bit_d   = 5'd23;
                                led_d   = led_q + ADDR_W'(1);
                            end
                            if (int'(led_q) + 2 < NUM_LEDS) begin
                                pix_rd_d   = 1'b1;
                                pix_addr_d = led_q + ADDR_W'(2);
                            end
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
            end
            S_LATCH: begin
                if (lat_end) begin
                    done_d = 1'b1;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: ;
        endcase
        if ((state_q != S_LATCH) && (state_d == S_LATCH)) begin
            lat_d = LAT_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q      <= '0;
            bit_q      <= '0;
            led_q      <= '0;
            lat_q      <= '0;
            bright_q   <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            cap_q      <= 1'b0;
            pix_rd_q   <= 1'b0;
            pix_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            leds_q     <= '0;
        end else begin
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            led_q      <= led_d;
            lat_q      <= lat_d;
            bright_q   <= bright_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            cap_q      <= cap_d;
            pix_rd_q   <= pix_rd_d;
            pix_addr_q <= pix_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            leds_q     <= leds_d;
        end
    end

    assign pix_rd   = pix_rd_q;
    assign pix_addr = pix_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign leds     = leds_q;

endmodule

// File: tb/tb_ws2812_multi_driver.sv
// Directed bench for ws2812_multi_driver: 2 strips x 2 LEDs, short bit timing,
// each frame traced cycle by cycle and compared against hand-derived waveforms.
module tb_ws2812_multi_driver;

    localparam int NCH  = 2;
    localparam int NLED = 2;
    localparam int AW   = 1;
    localparam int TB   = 10;
    localparam int T0   = 3;
    localparam int T1   = 7;
    localparam int TR   = 20;
    localparam int NPER = NLED * 24;
    localparam int MAXK = 1000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [7:0]           brightness = 8'd0;
    logic                 pix_rd;
    logic [AW-1:0]        pix_addr;
    logic [24*NCH-1:0]    pix_data = '0;
    logic                 busy;
    logic                 done;
    logic [NCH-1:0]       leds;

    logic [24*NCH-1:0]    ram [NLED];

    int n_assert = 0;
    int n_fail   = 0;

    logic [NCH-1:0] leds_tr [MAXK];
    logic           rd_tr   [MAXK];
    logic [AW-1:0]  addr_tr [MAXK];
    logic           done_tr [MAXK];
    logic           busy_tr [MAXK];
    int             last_k;

    ws2812_multi_driver #(
        .NUM_CH   (NCH),
        .NUM_LEDS (NLED),
        .ADDR_W   (AW),
        .T_BIT    (TB),
        .T0H      (T0),
        .T1H      (T1),
        .T_RESET  (TR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .brightness (brightness),
        .pix_rd     (pix_rd),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .busy       (busy),
        .done       (done),
        .leds       (leds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pix_rd) pix_data <= ram[pix_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Index k counts clk edges after the start-sample edge; samples are taken 1 ns after each edge.
    task automatic run_frame(input logic [7:0] br, input bit with_abort,
                             input int restart_k, input int abort_k, input int late_k);
        @(negedge clk);
        brightness = br;
        start = 1'b1;
        abort = with_abort;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < MAXK; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            leds_tr[k] = leds;
            rd_tr[k]   = pix_rd;
            addr_tr[k] = pix_addr;
            done_tr[k] = done;
            busy_tr[k] = busy;
            last_k     = k;
            start = (k == restart_k - 1) || (k == late_k - 1);
            abort = (k == abort_k - 1);
            if (k > 0 && !busy) break;
        end
        start = 1'b0;
        abort = 1'b0;
        check_eq("frame_end_busy", busy_tr[last_k], 1'b0);
    endtask

    task automatic check_frame(input string nm,
                               input logic [23:0] e00, input logic [23:0] e01,
                               input logic [23:0] e10, input logic [23:0] e11,
                               input int nper, input int done_exp, input int latch_from);
        logic [23:0]   ew [NCH][NLED];
        logic [TB-1:0] got_win;
        logic [TB-1:0] exp_win;
        logic [NCH-1:0] acc;
        int            h;
        int            rd_n;
        int            rd_k [2];
        logic [AW-1:0] rd_a [2];
        int            done_n;
        int            done_k;
        ew[0][0] = e00; ew[0][1] = e01; ew[1][0] = e10; ew[1][1] = e11;

        check_eq({nm, "_lead_low"}, leds_tr[0] | leds_tr[1] | leds_tr[2], '0);
        for (int p = 0; p < nper; p++) begin
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < TB; i++) got_win[i] = leds_tr[3 + TB*p + i][c];
                h = ew[c][p / 24][23 - (p % 24)] ? T1 : T0;
                for (int i = 0; i < TB; i++) exp_win[i] = (i < h);
                check_eq($sformatf("%s_ch%0d_per%0d", nm, c, p), got_win, exp_win);
            end
        end

        acc = '0;
        for (int k = latch_from; k <= last_k; k++) acc = acc | leds_tr[k];
        check_eq({nm, "_latch_low"}, acc, '0);

        done_n = 0;
        done_k = -1;
        for (int k = 0; k <= last_k; k++) begin
            if (done_tr[k]) begin
                if (done_n == 0) done_k = k;
                done_n++;
            end
        end
        check_eq({nm, "_done_cycle"}, done_k, done_exp);
        check_eq({nm, "_done_count"}, done_n, 1);
        check_eq({nm, "_busy_fall"}, last_k, done_exp + 1);

        rd_n = 0;
        rd_k[0] = -1; rd_k[1] = -1;
        rd_a[0] = '1; rd_a[1] = '0;
        for (int k = 0; k <= last_k; k++) begin
            if (rd_tr[k]) begin
                if (rd_n < 2) begin
                    rd_k[rd_n] = k;
                    rd_a[rd_n] = addr_tr[k];
                end
                rd_n++;
            end
        end
        check_eq({nm, "_rd_count"}, rd_n, 2);
        check_eq({nm, "_rd0_cycle"}, rd_k[0], 0);
        check_eq({nm, "_rd0_addr"}, rd_a[0], 0);
        check_eq({nm, "_rd1_cycle"}, rd_k[1], 2);
        check_eq({nm, "_rd1_addr"}, rd_a[1], 1);
    endtask

    initial begin
        logic idle_act;
        ram[0] = {24'h000001, 24'hFF0000};
        ram[1] = {24'h000000, 24'h800000};

        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_leds", leds, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_pix_rd", pix_rd, 1'b0);
        check_eq("rst_pix_addr", pix_addr, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full brightness: identity scaling, nominal 502-cycle frame.
        run_frame(8'd255, 1'b0, -1, -1, -1);
        check_frame("b255", 24'hFF0000, 24'h800000, 24'h000001, 24'h000000, NPER, 502, 483);

        // FF*128>>8 = 7F, 80*128>>8 = 40, 01*128>>8 = 00.
        run_frame(8'd127, 1'b0, -1, -1, -1);
        check_frame("b127", 24'h7F0000, 24'h400000, 24'h000000, 24'h000000, NPER, 502, 483);

        // Brightness 0 with abort alongside start: start wins, every bit is a 0-bit.
        run_frame(8'd0, 1'b1, -1, -1, -1);
        check_frame("b0_abort_start", 24'h0, 24'h0, 24'h0, 24'h0, NPER, 502, 483);

        // Start mid-frame and in the cycle busy falls: both ignored.
        run_frame(8'd255, 1'b0, 100, -1, 503);
        check_frame("restart", 24'hFF0000, 24'h800000, 24'h000001, 24'h000000, NPER, 502, 483);
        idle_act = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            idle_act = idle_act | busy | pix_rd;
        end
        check_eq("late_start_ignored", idle_act, 1'b0);

        // Abort sampled at edge 375, inside LED1 bit 10, cutting a high cycle of ch0.
        run_frame(8'd255, 1'b0, -1, 375, -1);
        check_frame("abort", 24'hFF0000, 24'h800000, 24'h000001, 24'h000000, 37, 395, 375);
        check_eq("abort_pre_high", leds_tr[374][0], 1'b1);
        check_eq("abort_cut", leds_tr[375], '0);

        // Asynchronous reset while ch0 is high in LED0 bit 19.
        @(negedge clk);
        brightness = 8'd255;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (45) @(posedge clk);
        #2;
        check_eq("pre_rst_led0", leds[0], 1'b1);
        check_eq("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_leds", leds, '0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        check_eq("mid_rst_pix_rd", pix_rd, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(8'd255, 1'b0, -1, -1, -1);
        check_frame("post_rst", 24'hFF0000, 24'h800000, 24'h000001, 24'h000000, NPER, 502, 483);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_multi_driver.md
Name: ws2812_multi_driver

Overview:
- Parametrised successor to the single-strip WS2812 serial driver.
- Drives NUM_CH independent WS2812 strips in lock-step, each strip carrying NUM_LEDS pixels of 24 bits, with configurable bit timing.
- Pixel data is fetched from an external frame RAM through a read port, and an 8-bit global brightness scale is applied on the fly.
- A start/busy/done handshake lets the POV sequencer trigger one frame per display slice.

Parameters:
NUM_CH, 4, number of parallel strip outputs
NUM_LEDS, 56, pixels per strip
ADDR_W, 6, pixel address width; must satisfy 2**ADDR_W >= NUM_LEDS
T_BIT, 125, clk cycles per bit period
T0H, 34, high cycles for a 0 bit; must be less than T1H
T1H, 89, high cycles for a 1 bit; must be less than T_BIT
T_RESET, 5900, low cycles of the latch gap after the last bit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle frame request; honoured only in IDLE
abort  in  1  terminates the current frame and enters LATCH
brightness  in  8  global scale factor, sampled on accepted start
pix_rd  out  1  frame RAM read strobe
pix_addr  out  ADDR_W  pixel index being fetched
pix_data  in  24*NUM_CH  channel c occupies bits [24c+23:24c]; valid one cycle after pix_rd
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of the latch gap
leds  out  NUM_CH  serial data lines, registered

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0 (leds, busy, done, pix_rd, pix_addr). FSM returns to IDLE and all counters clear. Reset asserted mid-frame terminates the frame immediately with no done pulse.
- FSM states: IDLE, FETCH, WAIT, SHIFT, LATCH.
- IDLE:
  - start=1 is accepted: latch brightness, busy<=1, go to FETCH.
- FETCH (1 cycle): pix_rd=1, pix_addr=0.
- WAIT (1 cycle):
  - Capture pix_data.
  - Per channel and per byte: scaled = (byte*(brightness+1))>>8, so brightness 255 gives identity and 0 gives 0.
  - Load the scaled words into the shift registers and go to SHIFT.
- First rising edge on leds occurs on the 3rd clk edge after the edge that samples start.
- SHIFT:
  - Bit counter runs 23 down to 0, MSB first, byte order as stored (G, R, B).
  - Cycle counter runs 0..T_BIT-1.
  - leds[c] = 1 while cycle counter < (bit ? T1H : T0H), else 0.
  - All channels share one timebase.
- Prefetch:
  - At cycle counter 0 of bit 23 of LED n with n < NUM_LEDS-1: pix_rd=1, pix_addr=n+1.
  - The next cycle captures and scales pix_data into a holding register.
  - The holding register transfers to the shift register at the T_BIT-1 to 0 wrap of bit 0.
  - Frame data is therefore gapless: LED-to-LED boundaries carry no extra cycles.
- SHIFT exit: after bit 0 of LED NUM_LEDS-1 completes, go to LATCH.
- LATCH:
  - leds=0 for exactly T_RESET cycles.
  - done=1 on the final LATCH cycle.
  - busy deasserts on the following edge; state returns to IDLE.
- Frame length:
  - Start-sample edge to done is 2 + NUM_LEDS*24*T_BIT + T_RESET cycles.
  - busy deasserts one edge later.
- Handshake rules:
  - start while busy is ignored.
  - start in the same cycle that busy falls is ignored; start must be re-asserted once busy=0.
- abort:
  - In FETCH, WAIT or SHIFT: the next edge forces leds=0 and enters LATCH, running the full T_RESET gap. done is still pulsed.
  - abort in LATCH or IDLE has no effect.
  - abort and start together in IDLE: start wins.
- Widths:
  - Counters are sized with $clog2 of their maxima.
  - Scaling uses a 16-bit product per byte, truncated.
  - pix_addr never exceeds NUM_LEDS-1.
- pix_rd is high only in the fetch cycles described above; pix_addr holds its last value otherwise.

Test Plan:
- Bench parameters: NUM_CH=2, NUM_LEDS=2, T_BIT=10, T0H=3, T1H=7, T_RESET=20; RAM holds [0]={ch0 24'hFF0000, ch1 24'h000001}, [1]={24'h800000, 24'h0}.
- Reset, then brightness=255 and start pulse -> first high on leds at edge 3 after start. Bit 23: ch0 high 7 cycles, ch1 high 3 cycles. Bit 0 of LED0: ch1 high 7 cycles. done exactly 2+480+20=502 cycles after the start-sample edge.
- Same frame, gap check -> pix_rd pulses exactly twice, with addresses 0 and 1. No idle cycles between the 48 bit periods; every bit period measures 10 cycles rising-to-rising.
- brightness=127, pixel 24'hFF0000 -> transmitted byte 8'h7F, i.e. G bits pattern 0111_1111. brightness=0 -> every bit high for 3 cycles.
- Start re-pulsed while busy, mid-frame -> no effect, frame length unchanged. Abort during LED1 bit 10 -> leds=0 next edge, done after 20 low cycles, busy falls one edge later.
- rst_n pulled low during SHIFT -> leds, busy, done, pix_rd go to 0 immediately without a clk edge. After release, a new start produces the full nominal frame.
